tick_scheduler: RTL
===================

# tick_scheduler

Programmable two-channel tick generator and controller for the lab's slow-clock domain. It owns two divide counters and sequences them: start, stop, phase alignment, and glitch-free divisor reconfiguration through a valid/ready port. It provides one-cycle tick enables and 50%-duty slow-clock levels to downstream display and sequencing logic. All logic runs on the single board clock; no derived clocks are used as clock inputs.

## Interface
- CNT_W, 24, width of counters and divisors
- DIV1_DEFAULT, 10000000, channel 1 divisor after reset
- DIV2_DEFAULT, 2000000, channel 2 divisor after reset
- clk  input  1  board clock; sole clock of the block
- reset_n  input  1  reset, synchronous and active-low
- run  input  1  level; 1 = channels count, 0 = channels frozen
- cfg_valid  input  1  divisor write request
- cfg_sel  input  1  target channel: 0 = channel 1, 1 = channel 2
- cfg_div  input  CNT_W  new divisor D
- cfg_ready  output  1  write accepted when cfg_valid & cfg_ready at a clk edge
- tick_1, tick_2  output  1  one-cycle enable pulse per channel period
- slw_clk_1, slw_clk_2  output  1  toggles on every tick of its channel
- busy  output  1  state != STOPPED or any divisor pending

## Operation
- Per channel: cnt[CNT_W], div_act[CNT_W], div_pend[CNT_W], pend flag.
- Divisor D gives period D+1 cycles between ticks; D=0 ticks every cycle. Counter compare is unsigned equality with div_act; cnt never exceeds div_act.
- FSM states: STOPPED, ALIGN, RUNNING.
  - STOPPED: cnt holds, tick_x=0, slw_clk_x hold. run=1 -> ALIGN.
  - ALIGN (exactly one cycle): both cnt<=0, both slw_clk_x<=0, tick_x=0. -> RUNNING if run=1, else STOPPED.
  - RUNNING: per channel, if cnt==div_act then cnt<=0, tick_x<=1, slw_clk_x toggles, and div_act<=div_pend with pend cleared if pend set; else cnt<=cnt+1, tick_x<=0. run=0 -> STOPPED; the counters do not advance on that edge.
- cfg_ready = ~pend of the channel selected by cfg_sel (combinational from cfg_sel).
- Accepted write, RUNNING: div_pend<=cfg_div, pend<=1; applied at that channel's next wrap.
- Accepted write, STOPPED or ALIGN: div_pend<=cfg_div, pend<=1; applied on the next edge in STOPPED or ALIGN (div_act<=div_pend, cnt<=0, pend cleared). If the FSM is in RUNNING by then, the write is applied at the next wrap instead.
- Reset (any state, mid-period included): state=STOPPED, cnt=0, div_act=DIVx_DEFAULT, pend=0, tick_x=0, slw_clk_x=0, cfg_ready=1, busy=0.

## Timing
- All outputs except cfg_ready are registered.
- run sampled high at edge E0 in STOPPED: ALIGN after E0, RUNNING after E1. The first tick_x is high in the cycle after edge E(D+2). Subsequent ticks come every D+1 cycles.
- Write accepted at an edge coincident with a wrap on the same channel: that wrap uses the old div_act. The new value applies at the following wrap.
- Pending write: cfg_ready for that channel is low from the cycle after acceptance until the cycle after the applying edge.
- Writes to the two channels are independent; both may be pending simultaneously.
- run falling at the same edge as a wrap: the wrap does not occur. The frozen cnt equals div_act and wraps on the first RUNNING edge after ALIGN only if ALIGN is skipped; ALIGN is never skipped, so cnt restarts at 0.

## Configuration
- TICK_SCHEDULER_TICKCNT_EN defined: adds outputs tick_cnt_1[7:0] and tick_cnt_2[7:0]. Each is an 8-bit count of ticks on its channel; 255 wraps to 0; reset to 0; not cleared by ALIGN.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with DIV1_DEFAULT=3, DIV2_DEFAULT=1, run=1 sampled at E0 -> tick_1 high after E5, E9, E13; tick_2 high after E3, E5, E7; slw_clk_1 = 1 after E5 and 0 after E9.
- While RUNNING with D1=3, write cfg_sel=0, cfg_div=0 mid-period -> cfg_ready low until wrap; after the wrap, tick_1 is high every cycle.
- Write coincident with a channel 1 wrap -> next period still 4 cycles; the period after uses the new D.
- Drop run for 5 cycles mid-period, then raise it -> outputs hold while stopped; ALIGN clears slw_clk_x to 0; first tick D+2 edges after run is resampled high.
- Assert reset_n=0 for one edge mid-period with pend set -> all outputs are at reset values on the next cycle, pend cleared, and div_act returns to the defaults.
- With TICK_SCHEDULER_TICKCNT_EN and D2=0 for 256 RUNNING cycles -> tick_cnt_2 wraps to 0.

Source files
------------

// File: rtl/tick_scheduler.sv
// Two-channel tick generator: divide counters, start/stop/align sequencing, and
// pending divisor writes. Optional tick counters are enabled by TICK_SCHEDULER_TICKCNT_EN.
module tick_scheduler #(
  parameter int          CNT_W        = 24,
  parameter int unsigned DIV1_DEFAULT = 10000000,
  parameter int unsigned DIV2_DEFAULT = 2000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick_1,
  output logic             tick_2,
  output logic             slw_clk_1,
  output logic             slw_clk_2,
  output logic             busy
`ifdef TICK_SCHEDULER_TICKCNT_EN
  ,
  output logic [7:0]       tick_cnt_1,
  output logic [7:0]       tick_cnt_2
`endif
);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    ALIGN   = 2'd1,
    RUNNING = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][CNT_W-1:0] div_act_q, div_act_d;
  logic [1:0][CNT_W-1:0] div_pend_q, div_pend_d;
  logic [1:0][CNT_W-1:0] div_default;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            tick_q, tick_d;
  logic [1:0]            slw_q, slw_d;
  logic [1:0]            accept;
  logic                  busy_q, busy_d;

  assign div_default[0] = CNT_W'(DIV1_DEFAULT);
  assign div_default[1] = CNT_W'(DIV2_DEFAULT);

  // A channel only accepts a new divisor once its previous one has been applied.
  assign cfg_ready = ~pend_q[cfg_sel];
  assign accept[0] = cfg_valid & ~cfg_sel & ~pend_q[0];
  assign accept[1] = cfg_valid &  cfg_sel & ~pend_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    tick_d     = '0;
    slw_d      = slw_q;

    case (state_q)
      STOPPED: if (run) state_d = ALIGN;
      ALIGN:   state_d = run ? RUNNING : STOPPED;
      RUNNING: if (!run) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase

    for (int i = 0; i < 2; i++) begin
      case (state_q)
        STOPPED, ALIGN: begin
          if (state_q == ALIGN) begin
            cnt_d[i] = '0;
            slw_d[i] = 1'b0;
          end
          if (pend_q[i]) begin
            div_act_d[i] = div_pend_q[i];
            cnt_d[i]     = '0;
            pend_d[i]    = 1'b0;
          end
        end
        RUNNING: begin
          // Dropping run freezes the counter on this edge, so no wrap happens.
          if (run) begin
            if (cnt_q[i] == div_act_q[i]) begin
              cnt_d[i]  = '0;
              tick_d[i] = 1'b1;
              slw_d[i]  = ~slw_q[i];
              if (pend_q[i]) begin
                div_act_d[i] = div_pend_q[i];
                pend_d[i]    = 1'b0;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase

      if (accept[i]) begin
        div_pend_d[i] = cfg_div;
        pend_d[i]     = 1'b1;
      end
    end

    busy_d = (state_d != STOPPED) | (|pend_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= STOPPED;
      cnt_q      <= '0;
      div_act_q  <= div_default;
      div_pend_q <= div_default;
      pend_q     <= '0;
      tick_q     <= '0;
      slw_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      slw_q      <= slw_d;
      busy_q     <= busy_d;
    end
  end

  assign tick_1    = tick_q[0];
  assign tick_2    = tick_q[1];
  assign slw_clk_1 = slw_q[0];
  assign slw_clk_2 = slw_q[1];
  assign busy      = busy_q;

`ifdef TICK_SCHEDULER_TICKCNT_EN
  logic [1:0][7:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (tick_d[i]) tick_cnt_d[i] = tick_cnt_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) tick_cnt_q <= '0;
    else          tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt_1 = tick_cnt_q[0];
  assign tick_cnt_2 = tick_cnt_q[1];
`endif

endmodule
